// File: rtl/mux_bufe_oe_arbiter.sv
// Round-robin OE generator for BUFE bus slices: zero/one-hot OE with a dead gap between drivers.
// OE rises C_DEAD_CYCLES+1 CE-edges after a request is seen in IDLE; CE low freezes everything.
module mux_bufe_oe_arbiter #(
    parameter int C_NUM_SRC     = 4,
    parameter int C_DEAD_CYCLES = 1,
    parameter int C_MAX_HOLD    = 16,
    parameter int C_ID_WIDTH    = 2
) (
    input  logic                  CLK,
    input  logic                  ACLR,
    input  logic                  CE,
    input  logic [C_NUM_SRC-1:0]  REQ,
    output logic [C_NUM_SRC-1:0]  OE,
    output logic [C_ID_WIDTH-1:0] GNT_ID,
    output logic                  BUS_VALID,
    output logic                  BUSY
);

    localparam int IW = (C_NUM_SRC > 1) ? $clog2(C_NUM_SRC) : 1;
    localparam int HW = (C_MAX_HOLD > 1) ? $clog2(C_MAX_HOLD) : 1;
    localparam bit GAP_EN  = (C_DEAD_CYCLES > 0);
    localparam bit HOLD_EN = (C_MAX_HOLD > 0);
    localparam logic [3:0]    GAP_LAST  = 4'(GAP_EN ? C_DEAD_CYCLES - 1 : 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_EN ? C_MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] SRC_LAST  = IW'(C_NUM_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gnt_q, gnt_d;
    logic [3:0]           gap_q, gap_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [C_NUM_SRC-1:0] oe_q, oe_d;
    logic [IW-1:0]        sel;

    function automatic logic [C_NUM_SRC-1:0] onehot(input logic [IW-1:0] idx);
        logic [C_NUM_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set request at or after ptr, wrapping modulo C_NUM_SRC.
    always_comb begin
        logic found;
        int   idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < C_NUM_SRC; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= C_NUM_SRC) idx = idx - C_NUM_SRC;
            if (!found && REQ[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            gap_q   <= '0;
            hold_q  <= '0;
            oe_q    <= '0;
        end else if (CE) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        oe_d    = oe_q;
        case (state_q)
            ST_IDLE: begin
                if (|REQ) begin
                    gnt_d  = sel;
                    gap_d  = '0;
                    hold_d = '0;
                    if (GAP_EN) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DRIVE;
                        oe_d    = onehot(sel);
                    end
                end
            end
            ST_GAP: begin
                // A grantee that withdraws before driving forfeits nothing: ptr stays put.
                if (!REQ[gnt_q]) begin
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ST_DRIVE;
                    oe_d    = onehot(gnt_q);
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            ST_DRIVE: begin
                if (!REQ[gnt_q] || (HOLD_EN && hold_q == HOLD_LAST)) begin
                    state_d = ST_IDLE;
                    oe_d    = '0;
                    hold_d  = '0;
                    ptr_d   = (gnt_q == SRC_LAST) ? '0 : gnt_q + 1'b1;
                end else if (HOLD_EN) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = '0;
            end
        endcase
    end

    always_comb begin
        OE             = oe_q;
        BUS_VALID      = |oe_q;
        BUSY           = (state_q != ST_IDLE);
        GNT_ID         = '0;
        GNT_ID[IW-1:0] = gnt_q;
    end

endmodule

// File: tb/tb_mux_bufe_oe_arbiter.sv
// Directed and randomized checks for mux_bufe_oe_arbiter with 4 sources, 1 dead cycle, hold limit 4.
module tb_mux_bufe_oe_arbiter;

    logic       CLK;
    logic       ACLR;
    logic       CE;
    logic [3:0] REQ;
    logic [3:0] OE;
    logic [1:0] GNT_ID;
    logic       BUS_VALID;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;

    mux_bufe_oe_arbiter #(
        .C_NUM_SRC    (4),
        .C_DEAD_CYCLES(1),
        .C_MAX_HOLD   (4),
        .C_ID_WIDTH   (2)
    ) dut (
        .CLK      (CLK),
        .ACLR     (ACLR),
        .CE       (CE),
        .REQ      (REQ),
        .OE       (OE),
        .GNT_ID   (GNT_ID),
        .BUS_VALID(BUS_VALID),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [3:0] exp_oe;
        logic [3:0] prev_oe;
        int         zeros;

        ACLR = 1'b1;
        CE   = 1'b1;
        REQ  = 4'b0000;
        repeat (2) @(negedge CLK);
        check("rst_oe", 32'(OE), 32'h0);
        check("rst_gnt", 32'(GNT_ID), 32'h0);
        check("rst_bv", 32'(BUS_VALID), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        ACLR = 1'b0;

        // Request withdrawn during the gap: no OE, ptr stays 0.
        REQ = 4'b0010;
        step();
        check("abort_gap_busy", 32'(BUSY), 32'h1);
        check("abort_gap_oe", 32'(OE), 32'h0);
        REQ = 4'b0000;
        step();
        check("abort_idle_busy", 32'(BUSY), 32'h0);
        check("abort_idle_oe", 32'(OE), 32'h0);
        REQ = 4'b0011;
        step();
        check("abort_next_gap_oe", 32'(OE), 32'h0);
        step();
        check("abort_next_oe", 32'(OE), 32'h1);
        check("abort_next_gnt", 32'(GNT_ID), 32'h0);
        REQ = 4'b0000;
        step();
        check("abort_release_oe", 32'(OE), 32'h0);

        // Single request, ptr=1 -> source 2 after two edges.
        REQ = 4'b0100;
        step();
        check("single_gap_oe", 32'(OE), 32'h0);
        check("single_gap_busy", 32'(BUSY), 32'h1);
        check("single_gap_gnt", 32'(GNT_ID), 32'h2);
        step();
        check("single_oe", 32'(OE), 32'h4);
        check("single_bv", 32'(BUS_VALID), 32'h1);
        check("single_gnt", 32'(GNT_ID), 32'h2);
        REQ = 4'b0000;
        step();
        check("single_drop_oe", 32'(OE), 32'h0);
        check("single_drop_busy", 32'(BUSY), 32'h0);

        // Async reset mid-DRIVE, then grant restarts from ptr=0.
        REQ = 4'b1000;
        step();
        step();
        check("rstmid_pre_oe", 32'(OE), 32'h8);
        #2 ACLR = 1'b1;
        #1;
        check("rstmid_oe", 32'(OE), 32'h0);
        check("rstmid_busy", 32'(BUSY), 32'h0);
        check("rstmid_gnt", 32'(GNT_ID), 32'h0);
        ACLR = 1'b0;
        REQ  = 4'b1111;
        step();
        step();
        check("rstmid_regrant_oe", 32'(OE), 32'h1);
        check("rstmid_regrant_gnt", 32'(GNT_ID), 32'h0);

        // Round robin 0,1,2,3,0: four OE cycles each, two all-low cycles between.
        for (int k = 0; k < 5; k++) begin
            exp_oe = 4'b0001 << (k % 4);
            check($sformatf("rr%0d_gnt", k), 32'(GNT_ID), 32'(k % 4));
            for (int c = 0; c < 4; c++) begin
                check($sformatf("rr%0d_oe%0d", k, c), 32'(OE), 32'(exp_oe));
                step();
            end
            if (k < 4) begin
                for (int c = 0; c < 2; c++) begin
                    check($sformatf("rr%0d_gap%0d", k, c), 32'(OE), 32'h0);
                    step();
                end
            end
        end
        REQ = 4'b0000;
        check("rr_end_oe", 32'(OE), 32'h0);
        step();

        // CE low in DRIVE freezes OE; the grant still spans four CE=1 cycles.
        REQ = 4'b0010;
        step();
        step();
        check("ce_d0", 32'(OE), 32'h2);
        step();
        check("ce_d1", 32'(OE), 32'h2);
        CE = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("ce_frozen%0d", c), 32'(OE), 32'h2);
        end
        CE = 1'b1;
        step();
        check("ce_d2", 32'(OE), 32'h2);
        step();
        check("ce_d3", 32'(OE), 32'h2);
        step();
        check("ce_exit", 32'(OE), 32'h0);
        REQ = 4'b0000;
        step();

        // Random REQ/CE with rare resets: structural invariants only.
        zeros   = 99;
        prev_oe = 4'b0000;
        for (int i = 0; i < 4000; i++) begin
            REQ = 4'($urandom);
            CE  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 ACLR = 1'b1;
                #1 check("rnd_rst_oe", 32'(OE), 32'h0);
                #1 ACLR = 1'b0;
            end
            step();
            check("rnd_onehot", 32'($onehot0(OE)), 32'h1);
            check("rnd_bv", 32'(BUS_VALID), 32'(|OE));
            if (OE != 4'b0000 && prev_oe == 4'b0000)
                check("rnd_gap", 32'(zeros >= 2), 32'h1);
            if (OE == 4'b0000) zeros++;
            else zeros = 0;
            prev_oe = OE;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
